gates_arbiter: RTL

Round-robin arbiter and sequencer that time-shares one registered bitwise logic unit (OR / AND / NOT) between two requesters. Each requester presents operands and an opcode under a req/grant/done handshake. The block latches the winner's operands, computes the result, returns it with a one-cycle done pulse, and keeps an operation counter. It sits between the switch/peripheral front-ends and the shared gate datapath on the lab board.

---
 rtl/gates_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/gates_arbiter.sv
// Round-robin arbiter that time-shares one registered OR/AND/NOT unit between
// two req/grant/done requesters and counts completed operations.
module gates_arbiter #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic [WIDTH-1:0]     opA0,
  input  logic [WIDTH-1:0]     opB0,
  input  logic [1:0]           opSel0,
  output logic                 grant0,
  output logic                 done0,
  input  logic                 req1,
  input  logic [WIDTH-1:0]     opA1,
  input  logic [WIDTH-1:0]     opB1,
  input  logic [1:0]           opSel1,
  output logic                 grant1,
  output logic                 done1,
  output logic [WIDTH-1:0]     result,
  output logic                 err,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] opCount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_OR  = 2'b00,
    OP_AND = 2'b01,
    OP_NOT = 2'b10,
    OP_RSV = 2'b11
  } opcode_t;

  state_t               state_reg, state_next;
  logic [1:0]           req_vec;
  logic [WIDTH-1:0]     req_a   [2];
  logic [WIDTH-1:0]     req_b   [2];
  logic [1:0]           req_sel [2];

  logic                 ptr_reg;
  logic                 winner;
  logic                 owner_reg, owner_next;
  logic                 latch_en, exec_en, finish_en;

  logic [WIDTH-1:0]     a_reg, b_reg;
  opcode_t              sel_reg;
  logic [WIDTH-1:0]     alu_out;

  logic [1:0]           grant_reg, grant_next;
  logic [1:0]           done_reg, done_next;
  logic                 err_reg, busy_reg;
  logic [WIDTH-1:0]     result_reg;
  logic [CNT_WIDTH-1:0] count_reg;

  assign req_vec    = {req1, req0};
  assign req_a[0]   = opA0;
  assign req_a[1]   = opA1;
  assign req_b[0]   = opB0;
  assign req_b[1]   = opB1;
  assign req_sel[0] = opSel0;
  assign req_sel[1] = opSel1;

  // A lone requester always wins; on a tie the priority pointer decides.
  always_comb begin
    winner = ptr_reg;
    if (req_vec == 2'b01) begin
      winner = 1'b0;
    end else if (req_vec == 2'b10) begin
      winner = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    latch_en   = 1'b0;
    exec_en    = 1'b0;
    finish_en  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|req_vec) begin
          latch_en   = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        exec_en    = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        finish_en  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign owner_next = latch_en ? winner : owner_reg;

  always_comb begin
    alu_out = '0;
    case (sel_reg)
      OP_OR:   alu_out = a_reg | b_reg;
      OP_AND:  alu_out = a_reg & b_reg;
      OP_NOT:  alu_out = ~a_reg;
      OP_RSV:  alu_out = '0;
      default: alu_out = '0;
    endcase
  end

  // Grant and done are registered from next-state so they line up with EXEC/DONE.
  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    assign grant_next[gi] = (state_next != IDLE) && (owner_next == 1'(gi));
    assign done_next[gi]  = exec_en && (owner_reg == 1'(gi));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sel_reg   <= OP_OR;
      owner_reg <= 1'b0;
    end else if (latch_en) begin
      a_reg     <= req_a[winner];
      b_reg     <= req_b[winner];
      sel_reg   <= opcode_t'(req_sel[winner]);
      owner_reg <= winner;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= 1'b0;
    end else if (finish_en) begin
      ptr_reg <= ~owner_reg;
    end
  end

  // Result and counter update on the EXEC->DONE edge so both are visible with done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_reg  <= '0;
      done_reg   <= '0;
      err_reg    <= 1'b0;
      busy_reg   <= 1'b0;
      result_reg <= '0;
      count_reg  <= '0;
    end else begin
      grant_reg <= grant_next;
      done_reg  <= done_next;
      err_reg   <= exec_en && (sel_reg == OP_RSV);
      busy_reg  <= (state_next != IDLE);
      if (exec_en) begin
        result_reg <= alu_out;
        count_reg  <= count_reg + CNT_WIDTH'(1);
      end
    end
  end

  assign grant0  = grant_reg[0];
  assign grant1  = grant_reg[1];
  assign done0   = done_reg[0];
  assign done1   = done_reg[1];
  assign err     = err_reg;
  assign busy    = busy_reg;
  assign result  = result_reg;
  assign opCount = count_reg;

endmodule
